// File: rtl/i2c_temp_reader.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_temp_reader
//  Description : I2C master that reads a two-byte temperature word from the
//                on-board sensor once per poll interval and presents it as
//                an integer Celsius value clamped to 0..99.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_temp_reader #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h4B,
    parameter int unsigned QTR_DIV     = 250,
    parameter int unsigned POLL_CYCLES = 100_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    output wire        SCL,
    inout  wire        SDA,
    output logic [7:0] temp_data,
    output logic       temp_valid,
    output logic       ack_error
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_ADDR     = 4'd2,
        S_ADDR_ACK = 4'd3,
        S_RD_MSB   = 4'd4,
        S_M_ACK    = 4'd5,
        S_RD_LSB   = 4'd6,
        S_M_NACK   = 4'd7,
        S_STOP     = 4'd8
    } state_t;

    localparam int unsigned c_DIV_W     = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam int unsigned c_POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(QTR_DIV - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_CYCLES - 1);
    localparam logic [7:0]          c_ADDR_RD   = {SLAVE_ADDR, 1'b1};

    state_t              state_q, state_d;
    logic [c_DIV_W-1:0]  div_q, div_d;
    logic [c_POLL_W-1:0] poll_q, poll_d;
    logic [1:0]          qtr_q, qtr_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          msb_q, msb_d;
    logic [7:0]          lsb_q, lsb_d;
    logic                nack_q, nack_d;
    logic                scl_low_q, scl_low_d;
    logic                sda_low_q, sda_low_d;
    logic [7:0]          temp_q, temp_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic       w_tick;
    logic       w_sample;
    logic       w_last;
    logic       w_sda_in;
    logic [7:0] w_raw;
    logic [7:0] w_temp;

    assign w_tick   = (div_q == c_DIV_LAST);
    assign w_sample = w_tick && (qtr_q == 2'd1);   // edge entering Q2
    assign w_last   = w_tick && (qtr_q == 2'd3);   // edge entering next Q0
    assign w_sda_in = SDA;

    // Whole degrees from the sensor word; negative readings floor at zero
    assign w_raw  = {msb_q[6:0], lsb_q[7]};
    assign w_temp = msb_q[7] ? 8'd0 : ((w_raw > 8'd99) ? 8'd99 : w_raw);

    // Open-drain pin levels for a given position: {scl_low, sda_low}
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qtr,
                                             input logic [2:0] bitn);
        logic scl_low;
        logic sda_low;
        scl_low = (qtr < 2'd2);
        sda_low = 1'b0;
        case (st)
            S_IDLE:  scl_low = 1'b0;
            S_START: begin
                scl_low = 1'b0;
                sda_low = 1'b1;
            end
            S_ADDR:  sda_low = ~c_ADDR_RD[3'd7 - bitn];
            S_M_ACK: sda_low = 1'b1;
            S_STOP:  sda_low = (qtr != 2'd3);
            default: sda_low = 1'b0;
        endcase
        return {scl_low, sda_low};
    endfunction

    // Next-state: poll timer, quarter-period sequencing, shifting and result load
    always_comb begin
        state_d = state_q;
        div_d   = w_tick ? '0 : div_q + c_DIV_W'(1);
        poll_d  = '0;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;
        nack_d  = nack_q;
        temp_d  = temp_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (w_tick) begin
            qtr_d = qtr_q + 2'd1;
        end
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                qtr_d = 2'd0;
                bit_d = 3'd0;
                if (poll_q == c_POLL_LAST) begin
                    state_d = S_START;
                end else begin
                    poll_d = poll_q + c_POLL_W'(1);
                end
            end
            S_START: begin
                // One quarter of SDA-low with SCL high, then first SCL low
                if (w_tick) begin
                    state_d = S_ADDR;
                    qtr_d   = 2'd0;
                end
            end
            S_ADDR: begin
                if (w_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (w_sample) nack_d = w_sda_in;
                if (w_last) begin
                    if (nack_q) begin
                        err_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_RD_MSB;
                    end
                end
            end
            S_RD_MSB: begin
                if (w_sample) msb_d = {msb_q[6:0], w_sda_in};
                if (w_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_M_ACK;
                end
            end
            S_M_ACK: begin
                if (w_last) state_d = S_RD_LSB;
            end
            S_RD_LSB: begin
                if (w_sample) lsb_d = {lsb_q[6:0], w_sda_in};
                if (w_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_M_NACK;
                end
            end
            S_M_NACK: begin
                if (w_last) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_last) begin
                    state_d = S_IDLE;
                    if (!nack_q) begin
                        temp_d  = w_temp;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        {scl_low_d, sda_low_d} = bus_drive(state_d, qtr_d, bit_d);
    end

    // State and pin-drive registers; reset releases the bus at once
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            poll_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            msb_q     <= 8'd0;
            lsb_q     <= 8'd0;
            nack_q    <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            temp_q    <= 8'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            poll_q    <= poll_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            nack_q    <= nack_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            temp_q    <= temp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign SCL        = scl_low_q ? 1'b0 : 1'bz;
    assign SDA        = sda_low_q ? 1'b0 : 1'bz;
    assign temp_data  = temp_q;
    assign temp_valid = valid_q;
    assign ack_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_temp_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_temp_reader
//  Description : Bench for i2c_temp_reader with pull-ups, a behavioural
//                sensor slave and a bus-level protocol monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_temp_reader;

    localparam int unsigned c_QTR  = 4;
    localparam int unsigned c_POLL = 50;

    logic       clk_100MHz;
    logic       reset_n;
    wire        scl_bus;
    wire        sda_bus;
    logic [7:0] temp_data;
    logic       temp_valid;
    logic       ack_error;

    int n_checks = 0;
    int n_errors = 0;

    // Slave configuration and monitor state
    logic       cfg_present = 1'b1;
    logic [7:0] cfg_msb     = 8'h00;
    logic [7:0] cfg_lsb     = 8'h00;
    int         ph          = 0;    // 0 idle,1 addr,2 addr ack,3 msb,4 mack,5 lsb,6 mnack,7 await stop
    int         bitn        = 0;
    logic [7:0] sh          = 8'h00;
    logic [7:0] tx          = 8'h00;
    logic       s_low       = 1'b0;
    logic       got_ack     = 1'b0;
    logic [7:0] addr_seen   = 8'h00;
    logic       mack_bit    = 1'b1;
    logic       mnack_bit   = 1'b0;
    int         stops       = 0;
    int         valid_cnt   = 0;
    int         viol        = 0;
    int         width_viol  = 0;

    int stops0;
    int valid0;
    int exp_temp = 0;

    pullup (scl_bus);
    pullup (sda_bus);
    assign sda_bus = (s_low && reset_n) ? 1'b0 : 1'bz;

    i2c_temp_reader #(
        .SLAVE_ADDR  (7'h4B),
        .QTR_DIV     (c_QTR),
        .POLL_CYCLES (c_POLL)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .SCL        (scl_bus),
        .SDA        (sda_bus),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .ack_error  (ack_error)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Sensor word is 16-bit two's complement, 1/128 degC per LSB
    function automatic int model_temp(input logic [7:0] m, input logic [7:0] l);
        int word;
        int deg;
        word = {m, l};
        if (word >= 32768) return 0;
        deg = word / 128;
        return (deg > 99) ? 99 : deg;
    endfunction

    // Behavioural slave and protocol monitor, sampled mid-cycle
    initial begin
        logic p_scl;
        logic p_sda;
        logic p_valid;
        logic scl_s;
        logic sda_s;
        p_scl   = 1'b1;
        p_sda   = 1'b1;
        p_valid = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            scl_s = scl_bus;
            sda_s = sda_bus;
            if (temp_valid) begin
                valid_cnt++;
                if (p_valid) width_viol++;
            end
            p_valid = temp_valid;
            if (!reset_n) begin
                ph    = 0;
                s_low = 1'b0;
            end else if (p_scl && scl_s && (p_sda != sda_s)) begin
                if (!sda_s) begin
                    if (ph != 0) viol++;
                    ph        = 1;
                    bitn      = 0;
                    sh        = 8'h00;
                    addr_seen = 8'h00;
                    mack_bit  = 1'b1;
                    mnack_bit = 1'b0;
                end else begin
                    if (ph != 7) viol++;
                    ph = 0;
                    stops++;
                end
            end else if (!p_scl && scl_s) begin
                case (ph)
                    1: begin sh = {sh[6:0], sda_s}; bitn++; end
                    3, 5: bitn++;
                    4: mack_bit = sda_s;
                    6: mnack_bit = sda_s;
                    default: ;
                endcase
            end else if (p_scl && !scl_s) begin
                case (ph)
                    1: if (bitn == 8) begin
                        addr_seen = sh;
                        got_ack   = cfg_present && (sh == 8'h97);
                        s_low     = got_ack;
                        ph        = 2;
                    end
                    2: if (got_ack) begin
                        ph = 3; bitn = 0; tx = cfg_msb; s_low = ~tx[7];
                    end else begin
                        ph = 7; s_low = 1'b0;
                    end
                    3, 5: if (bitn == 8) begin
                        ph = ph + 1; s_low = 1'b0;
                    end else begin
                        s_low = ~tx[7-bitn];
                    end
                    4: begin ph = 5; bitn = 0; tx = cfg_lsb; s_low = ~tx[7]; end
                    6: begin ph = 7; s_low = 1'b0; end
                    default: ;
                endcase
            end
            p_scl = scl_s;
            p_sda = sda_s;
        end
    end

    task automatic begin_txn(input logic present, input logic [7:0] m, input logic [7:0] l);
        cfg_present = present;
        cfg_msb     = m;
        cfg_lsb     = l;
        stops0      = stops;
        valid0      = valid_cnt;
    endtask

    task automatic end_txn(input logic present, input int exp);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk_100MHz);
            #1;
            if (stops != stops0) done = 1'b1;
        end
        if (!done) begin
            check_value("txn_timeout", 0, 1);
            return;
        end
        repeat (12) @(negedge clk_100MHz);
        #1;
        check_value("addr_byte", addr_seen, 8'h97);
        if (present) begin
            check_value("master_ack", mack_bit, 0);
            check_value("master_nack", mnack_bit, 1);
            check_value("valid_pulses", valid_cnt - valid0, 1);
            check_value("temp_data", temp_data, exp);
            check_value("ack_error_clr", ack_error, 0);
            exp_temp = exp;
        end else begin
            check_value("ack_error_set", ack_error, 1);
            check_value("no_valid", valid_cnt - valid0, 0);
            check_value("temp_hold", temp_data, exp);
        end
    endtask

    task automatic run_txn(input logic present, input logic [7:0] m, input logic [7:0] l,
                           input int exp);
        begin_txn(present, m, l);
        end_txn(present, exp);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] l;
        bit         hit;
        int         k;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        #1;
        check_value("rst_temp", temp_data, 0);
        check_value("rst_valid", temp_valid, 0);
        check_value("rst_ackerr", ack_error, 0);
        check_value("rst_scl", scl_bus, 1);
        check_value("rst_sda", sda_bus, 1);
        @(negedge clk_100MHz);
        reset_n = 1'b1;

        // Directed reads
        run_txn(1'b1, 8'h0C, 8'h80, 25);
        run_txn(1'b1, 8'h3E, 8'h00, 99);
        run_txn(1'b1, 8'hF3, 8'h80, 0);
        run_txn(1'b1, 8'h31, 8'h00, 98);
        run_txn(1'b1, 8'h32, 8'h00, 99);

        // Randomised reads against the reference model
        for (int i = 0; i < 5; i++) begin
            m = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            run_txn(1'b1, m, l, model_temp(m, l));
        end

        // Absent slave, then recovery
        run_txn(1'b1, 8'h1E, 8'h00, 60);
        run_txn(1'b0, 8'h00, 8'h00, exp_temp);
        m = 8'($urandom_range(1, 63));
        l = 8'($urandom_range(0, 255));
        run_txn(1'b1, m, l, model_temp(m, l));
        run_txn(1'b0, 8'h00, 8'h00, exp_temp);

        // Reset while the MSB is being read with SCL held low
        begin_txn(1'b1, 8'h0C, 8'h80);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk_100MHz);
            #1;
            if (ph == 3 && bitn == 3 && !scl_bus) hit = 1'b1;
        end
        check_value("reach_rd_msb", hit, 1);
        reset_n = 1'b0;
        #1;
        check_value("mrst_scl", scl_bus, 1);
        check_value("mrst_sda", sda_bus, 1);
        check_value("mrst_temp", temp_data, 0);
        check_value("mrst_valid", temp_valid, 0);
        check_value("mrst_ackerr", ack_error, 0);
        repeat (3) @(negedge clk_100MHz);
        begin_txn(1'b1, 8'h0C, 8'h80);
        reset_n = 1'b1;
        k = 0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk_100MHz);
            #1;
            k++;
            if (!sda_bus) hit = 1'b1;
        end
        check_value("start_after_rst", k, c_POLL);
        end_txn(1'b1, 25);

        check_value("protocol_viol", viol, 0);
        check_value("valid_width", width_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_temp_reader.md
I2C_TEMP_READER -- requirements
Module: i2c_temp_reader

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h4B: 7-bit I2C address of the on-board temperature sensor.
REQ-002 SHALL have parameter QTR_DIV, default 250: clk_100MHz cycles per quarter SCL period (100 kHz bus).
REQ-003 SHALL have parameter POLL_CYCLES, default 100_000_000: idle clocks between transactions (1 s).
REQ-004 SHALL have port clk_100MHz, input, 1 bit: the block's only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port SCL, output, 1 bit: open-drain; driven 0 or released to 1'bz.
REQ-007 SHALL have port SDA, inout, 1 bit: open-drain; driven 0 or released to 1'bz.
REQ-008 SHALL have port temp_data, output, 8 bits: integer Celsius temperature, 0..99, in the format the seven-segment driver consumes.
REQ-009 SHALL have port temp_valid, output, 1 bit: one-cycle pulse marking each temp_data update.
REQ-010 SHALL have port ack_error, output, 1 bit: sticky flag, last transaction got no address ACK.

Function
REQ-011 SHALL generate a tick every QTR_DIV clocks; each SCL period is four ticks, Q0..Q3: SCL low in Q0-Q1, released in Q2-Q3.
REQ-012 SHALL change SDA only at Q0 entry and sample SDA only at Q2 entry, except at START and STOP.
REQ-013 SHALL use states IDLE, START, ADDR, ADDR_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP.
REQ-014 In IDLE, SHALL release SCL and SDA and count POLL_CYCLES clocks, then go to START. The count starts at reset release and at STOP completion.
REQ-015 In START, SHALL pull SDA low while SCL is released, and hold it for one tick before the first SCL low.
REQ-016 In ADDR, SHALL shift out {SLAVE_ADDR, 1'b1} MSB first over 8 SCL periods.
REQ-017 In ADDR_ACK, SHALL release SDA and sample it. If 0, go to RD_MSB. If 1, set ack_error and go to STOP.
REQ-018 In RD_MSB and RD_LSB, SHALL release SDA and shift in 8 bits MSB first into msb_reg and lsb_reg.
REQ-019 In M_ACK, SHALL drive SDA 0 for one SCL period.
REQ-020 In M_NACK, SHALL release SDA for one SCL period.
REQ-021 In STOP, SHALL hold SDA low while SCL rises, then release SDA one tick later, then return to IDLE.
REQ-022 On STOP completion after a good read, SHALL load temp_data in a single clock edge, pulse temp_valid high for exactly that cycle, and clear ack_error.
REQ-023 temp_data conversion, with raw = {msb_reg[6:0], lsb_reg[7]}:
  - if msb_reg[7]=1 (negative temperature): temp_data = 0;
  - else if raw > 99: temp_data = 99;
  - else: temp_data = raw.
REQ-024 After an address NACK, SHALL leave temp_data unchanged and SHALL NOT pulse temp_valid.
REQ-025 SHALL NOT support clock stretching or multi-master arbitration; SCL is never sampled.

Reset
REQ-026 While reset_n=0, SHALL immediately:
  - release SCL and SDA;
  - force temp_data=0, temp_valid=0, ack_error=0;
  - force state=IDLE;
  - clear all counters and shift registers.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no STOP generated; the next START SHALL occur POLL_CYCLES clocks after reset release.

Verification
REQ-028 Bench SHALL use QTR_DIV=4, POLL_CYCLES=50, a pull-up model and a behavioural slave, and SHALL cover these directed cases:
  - Good read: slave ACKs, returns 0x0C,0x80 -> address byte 0x97 observed, master ACK after MSB, NACK after LSB, STOP, temp_data=25 with a single-cycle temp_valid.
  - Clamp high: slave returns 0x3E,0x00 (124 C) -> temp_data=99.
  - Negative: slave returns 0xF3,0x80 -> temp_data=0, temp_valid pulses.
  - No ACK: slave absent -> ack_error=1, STOP issued, temp_data holds previous value, no temp_valid; next good read clears ack_error.
  - Mid-read reset: reset_n low during RD_MSB -> SCL and SDA high-Z in the same cycle, outputs zero, next START exactly 50 clocks after release.
  - Protocol checker: SDA never changes while SCL is high, except at START and STOP.
